// File: rtl/cpu_pkg.sv
// Shared types and encodings for the instruction-decode / control FSM.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_REG
  } state_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  localparam logic [2:0] CL_MOVI    = 3'd0;
  localparam logic [2:0] CL_MOVR    = 3'd1;
  localparam logic [2:0] CL_ALU     = 3'd2;
  localparam logic [2:0] CL_CMP     = 3'd3;
  localparam logic [2:0] CL_ILLEGAL = 3'd4;

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction decoder: field slices, sign-extended immediates, class.
module instr_dec
  import cpu_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [2:0]  rn_o,
  output logic [2:0]  rd_o,
  output logic [2:0]  rm_o,
  output logic [1:0]  op_o,
  output logic [1:0]  sh_o,
  output logic [15:0] sximm5_o,
  output logic [15:0] sximm8_o,
  output logic [2:0]  cls_o
);

  logic [2:0] opcode;

  assign opcode   = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign rn_o     = ir_i[10:8];
  assign rd_o     = ir_i[7:5];
  assign sh_o     = ir_i[4:3];
  assign rm_o     = ir_i[2:0];
  assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};
  assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};

  always_comb begin
    cls_o = CL_ILLEGAL;
    if (opcode == OPC_MOV && op_o == OP_MOVI)      cls_o = CL_MOVI;
    else if (opcode == OPC_MOV && op_o == OP_MOVR) cls_o = CL_MOVR;
    else if (opcode == OPC_ALU && op_o == ALU_SUB) cls_o = CL_CMP;
    else if (opcode == OPC_ALU)                    cls_o = CL_ALU;
  end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus control FSM; every datapath control is a flop loaded
// from the next-state decode so outputs are glitch-free for the gated datapath clocks.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int RN_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic [WIDTH-1:0] in,
  output logic             w,
  output logic             illegal,
  output logic [RN_W-1:0]  readnum,
  output logic [RN_W-1:0]  writenum,
  output logic             write,
  output logic             vsel,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic [WIDTH-1:0] datapath_in
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic             w_q, w_d, illegal_q, illegal_d;
  logic [RN_W-1:0]  readnum_q, readnum_d, writenum_q, writenum_d;
  logic             write_q, write_d, vsel_q, vsel_d;
  logic             loada_q, loada_d, loadb_q, loadb_d, loadc_q, loadc_d, loads_q, loads_d;
  logic             asel_q, asel_d, bsel_q, bsel_d;
  logic [1:0]       shift_q, shift_d, aluop_q, aluop_d;
  logic [WIDTH-1:0] dpin_q, dpin_d;

  logic [2:0]  rn, rd, rm, cls;
  logic [1:0]  op, sh;
  logic [15:0] sximm5, sximm8;

  // Decoding ir_d lets datapath_in track the freshly latched IR during DECODE;
  // outside WAIT ir_d equals ir_q.
  instr_dec u_dec (
    .ir_i     (ir_d),
    .rn_o     (rn),
    .rd_o     (rd),
    .rm_o     (rm),
    .op_o     (op),
    .sh_o     (sh),
    .sximm5_o (sximm5),
    .sximm8_o (sximm8),
    .cls_o    (cls)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_WAIT: if (s) begin
        ir_d    = in;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (cls)
          CL_MOVI:        state_d = S_WRITE_IMM;
          CL_MOVR:        state_d = S_GET_B;
          CL_ALU, CL_CMP: state_d = S_GET_A;
          default:        state_d = S_WAIT;
        endcase
      end
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_ALU;
      S_ALU:       state_d = (cls == CL_CMP) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  always_comb begin
    w_d        = (state_d == S_WAIT);
    illegal_d  = (state_q == S_DECODE) && (cls == CL_ILLEGAL);
    readnum_d  = readnum_q;
    writenum_d = writenum_q;
    shift_d    = shift_q;
    aluop_d    = aluop_q;
    write_d    = 1'b0;
    vsel_d     = 1'b0;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    asel_d     = 1'b0;
    bsel_d     = 1'b0;
    dpin_d     = (state_d == S_WRITE_IMM) ? sximm8 : sximm5;
    case (state_d)
      S_WRITE_IMM: begin
        writenum_d = rn;
        vsel_d     = 1'b1;
        write_d    = 1'b1;
      end
      S_GET_A: begin
        readnum_d = rn;
        loada_d   = 1'b1;
      end
      S_GET_B: begin
        readnum_d = rm;
        loadb_d   = 1'b1;
      end
      S_ALU: begin
        shift_d = sh;
        asel_d  = (cls == CL_MOVR);
        aluop_d = (cls == CL_MOVR) ? ALU_ADD : op;
        if (cls == CL_CMP) loads_d = 1'b1;
        else               loadc_d = 1'b1;
      end
      S_WRITE_REG: begin
        writenum_d = rd;
        write_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_WAIT;
      ir_q       <= '0;
      w_q        <= 1'b1;
      illegal_q  <= 1'b0;
      readnum_q  <= '0;
      writenum_q <= '0;
      write_q    <= 1'b0;
      vsel_q     <= 1'b0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      asel_q     <= 1'b0;
      bsel_q     <= 1'b0;
      shift_q    <= '0;
      aluop_q    <= '0;
      dpin_q     <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      w_q        <= w_d;
      illegal_q  <= illegal_d;
      readnum_q  <= readnum_d;
      writenum_q <= writenum_d;
      write_q    <= write_d;
      vsel_q     <= vsel_d;
      loada_q    <= loada_d;
      loadb_q    <= loadb_d;
      loadc_q    <= loadc_d;
      loads_q    <= loads_d;
      asel_q     <= asel_d;
      bsel_q     <= bsel_d;
      shift_q    <= shift_d;
      aluop_q    <= aluop_d;
      dpin_q     <= dpin_d;
    end
  end

  assign w           = w_q;
  assign illegal     = illegal_q;
  assign readnum     = readnum_q;
  assign writenum    = writenum_q;
  assign write       = write_q;
  assign vsel        = vsel_q;
  assign loada       = loada_q;
  assign loadb       = loadb_q;
  assign loadc       = loadc_q;
  assign loads       = loads_q;
  assign asel        = asel_q;
  assign bsel        = bsel_q;
  assign shift       = shift_q;
  assign ALUop       = aluop_q;
  assign datapath_in = dpin_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: walks each instruction class state by state.
module tb_cpu_controller;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, s;
  logic [15:0] in;
  logic        w, illegal, write, vsel, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_in;
  logic [7:0]  en;

  int checks   = 0;
  int failures = 0;

  localparam logic [7:0] EN_NONE  = 8'b0000_0000;
  localparam logic [7:0] EN_WRITE = 8'b1000_0000;
  localparam logic [7:0] EN_WIMM  = 8'b1100_0000;
  localparam logic [7:0] EN_LOADA = 8'b0010_0000;
  localparam logic [7:0] EN_LOADB = 8'b0001_0000;
  localparam logic [7:0] EN_LOADC = 8'b0000_1000;
  localparam logic [7:0] EN_LOADS = 8'b0000_0100;
  localparam logic [7:0] EN_MOVR  = 8'b0000_1010;

  cpu_controller dut (
    .clk         (clk),
    .reset       (reset),
    .s           (s),
    .in          (in),
    .w           (w),
    .illegal     (illegal),
    .readnum     (readnum),
    .writenum    (writenum),
    .write       (write),
    .vsel        (vsel),
    .loada       (loada),
    .loadb       (loadb),
    .loadc       (loadc),
    .loads       (loads),
    .asel        (asel),
    .bsel        (bsel),
    .shift       (shift),
    .ALUop       (ALUop),
    .datapath_in (datapath_in)
  );

  assign en = {write, vsel, loada, loadb, loadc, loads, asel, bsel};

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    s     = 1'b0;
    in    = 16'h0000;
    step();
    step();
    check("rst_w", w, 1'b1);
    check("rst_illegal", illegal, 1'b0);
    check("rst_en", en, EN_NONE);
    check("rst_dpin", datapath_in, 16'h0000);
    reset = 1'b0;
    step();
    check("idle_w", w, 1'b1);

    // MOV R0,#-5
    in = 16'hD0FB;
    s  = 1'b1;
    step();
    s = 1'b0;
    check("movi_dec_w", w, 1'b0);
    check("movi_dec_en", en, EN_NONE);
    step();
    check("movi_wimm_en", en, EN_WIMM);
    check("movi_writenum", writenum, 3'd0);
    check("movi_dpin", datapath_in, 16'hFFFB);
    check("movi_wimm_w", w, 1'b0);
    step();
    check("movi_done_w", w, 1'b1);
    check("movi_done_en", en, EN_NONE);

    // ADD R2,R1,R0,LSL#1 with `in` disturbed mid-instruction
    in = 16'hA148;
    s  = 1'b1;
    step();
    s  = 1'b0;
    in = 16'hFFFF;
    check("add_dec_en", en, EN_NONE);
    step();
    check("add_geta_en", en, EN_LOADA);
    check("add_geta_rn", readnum, 3'd1);
    step();
    check("add_getb_en", en, EN_LOADB);
    check("add_getb_rm", readnum, 3'd0);
    step();
    check("add_alu_en", en, EN_LOADC);
    check("add_alu_shift", shift, SH_LSL);
    check("add_alu_op", ALUop, ALU_ADD);
    step();
    check("add_wreg_en", en, EN_WRITE);
    check("add_wreg_rd", writenum, 3'd2);
    check("add_wreg_w", w, 1'b0);
    step();
    check("add_done_w", w, 1'b1);
    check("add_done_en", en, EN_NONE);
    check("add_hold_shift", shift, SH_LSL);
    check("add_hold_writenum", writenum, 3'd2);

    // CMP R1,R0, s left high so MOV R3,R1,ASR follows back-to-back
    in = 16'hA900;
    s  = 1'b1;
    step();
    check("cmp_dec_w", w, 1'b0);
    in = 16'hC079;
    step();
    check("cmp_geta_en", en, EN_LOADA);
    check("cmp_geta_rn", readnum, 3'd1);
    step();
    check("cmp_getb_en", en, EN_LOADB);
    step();
    check("cmp_alu_en", en, EN_LOADS);
    check("cmp_alu_op", ALUop, ALU_SUB);
    check("cmp_alu_shift", shift, SH_NONE);
    step();
    check("cmp_done_w", w, 1'b1);
    check("cmp_done_en", en, EN_NONE);
    step();
    s = 1'b0;
    check("movr_dec_w", w, 1'b0);
    step();
    check("movr_getb_en", en, EN_MOVR & 8'b0 | EN_LOADB);
    check("movr_getb_rm", readnum, 3'd1);
    step();
    check("movr_alu_en", en, EN_MOVR);
    check("movr_alu_shift", shift, SH_ASR);
    check("movr_alu_op", ALUop, ALU_ADD);
    step();
    check("movr_wreg_en", en, EN_WRITE);
    check("movr_wreg_rd", writenum, 3'd3);
    step();
    check("movr_done_w", w, 1'b1);

    // Illegal encoding
    in = 16'h0000;
    s  = 1'b1;
    step();
    s = 1'b0;
    check("ill_dec_illegal", illegal, 1'b0);
    step();
    check("ill_wait_w", w, 1'b1);
    check("ill_pulse", illegal, 1'b1);
    check("ill_wait_en", en, EN_NONE);
    step();
    check("ill_pulse_end", illegal, 1'b0);

    // ADD interrupted by reset while in GET_B
    in = 16'hA148;
    s  = 1'b1;
    step();
    s = 1'b0;
    step();
    check("rstmid_geta_en", en, EN_LOADA);
    step();
    check("rstmid_getb_en", en, EN_LOADB);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstmid_w", w, 1'b1);
    check("rstmid_en", en, EN_NONE);
    check("rstmid_dpin", datapath_in, 16'h0000);
    step();
    check("rstmid_after_w", w, 1'b1);
    check("rstmid_after_en", en, EN_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
